// File: rtl/usb_config_packer.sv
`default_nettype none
// ============================================================================
// Module   : usb_config_packer
// Purpose  : Packs USB bulk-OUT bytes MSB-first into 32-bit configuration
//            words with a one-cycle write strobe and a session-active flag.
//            Optional word counter enabled by USB_PACKER_WORDCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module usb_config_packer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMER_WIDTH    = 24,
    parameter int STROBE_GAP     = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
`ifdef USB_PACKER_WORDCOUNT_EN
    output logic [15:0] word_count,
`endif
    output logic        ComActive
);

    localparam int GAP_W = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_STROBE  = 2'd2;
    localparam logic [1:0] c_GAP     = 2'd3;

    localparam logic [GAP_W-1:0]       c_GAP_LAST   = GAP_W'(STROBE_GAP - 1);
    localparam logic [TIMER_WIDTH-1:0] c_TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            shift_q, shift_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   active_q, active_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic w_accept;
    logic w_expire;

    assign w_accept = rx_valid && rx_ready;
    // An accept on the would-be expiry edge keeps the session alive.
    assign w_expire = active_q && !w_accept && (timer_q == c_TIMER_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= c_IDLE;
            idx_q    <= 2'd0;
            shift_q  <= 24'd0;
            wdata_q  <= 32'd0;
            active_q <= 1'b0;
            timer_q  <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wdata_q  <= wdata_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        wdata_d  = wdata_q;
        active_d = active_q;
        gap_d    = gap_q;
        timer_d  = timer_q;

        if (w_accept) begin
            timer_d = '0;
        end else if (active_q) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            c_STROBE: begin
                gap_d   = '0;
                state_d = (STROBE_GAP == 0) ? c_COLLECT : c_GAP;
            end
            c_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == c_GAP_LAST) begin
                    state_d = c_COLLECT;
                end
            end
            default: begin
            end
        endcase

        if (w_accept) begin
            active_d = 1'b1;
            if (idx_q == 2'd3) begin
                wdata_d = {shift_q, rx_data};
                shift_d = 24'd0;
                idx_d   = 2'd0;
                state_d = c_STROBE;
            end else begin
                shift_d = {shift_q[15:0], rx_data};
                idx_d   = idx_q + 2'd1;
                state_d = c_COLLECT;
            end
        end else if (w_expire) begin
            active_d = 1'b0;
            idx_d    = 2'd0;
            shift_d  = 24'd0;
            state_d  = c_IDLE;
            timer_d  = '0;
        end
    end

    always_comb begin
        rx_ready    = !reset && ((state_q == c_IDLE) || (state_q == c_COLLECT));
        WriteStrobe = (state_q == c_STROBE);
        WriteData   = wdata_q;
        ComActive   = active_q;
    end

`ifdef USB_PACKER_WORDCOUNT_EN
    logic [15:0] wc_q, wc_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            wc_q <= 16'd0;
        end else begin
            wc_q <= wc_d;
        end
    end

    always_comb begin
        wc_d = wc_q;
        if (w_expire) begin
            wc_d = 16'd0;
        end else if ((state_q == c_STROBE) && (wc_q != 16'hFFFF)) begin
            wc_d = wc_q + 16'd1;
        end
    end

    assign word_count = wc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_config_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_config_packer
// Purpose  : Self-checking bench for usb_config_packer against a byte-count
//            reference model. Word counter checks under USB_PACKER_WORDCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_config_packer;

    localparam int T   = 16;
    localparam int GAP = 2;

    logic        CLK;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
`ifdef USB_PACKER_WORDCOUNT_EN
    logic [15:0] word_count;
`endif

    usb_config_packer #(
        .TIMEOUT_CYCLES(T),
        .TIMER_WIDTH   (8),
        .STROBE_GAP    (GAP)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
`ifdef USB_PACKER_WORDCOUNT_EN
        .word_count (word_count),
`endif
        .ComActive  (ComActive)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: bytes-in-word count, blocked cycles, idle cycles.
    int          m_block, m_n, m_idle, m_wc;
    logic [31:0] m_word, m_wdata;
    bit          m_strobe, m_active;
    bit          last_acc;

    function automatic logic [34:0] exp_vec();
        return {(!reset && (m_block == 0)), m_strobe, m_active, m_wdata};
    endfunction

    function automatic logic [34:0] obs_vec();
        return {rx_ready, WriteStrobe, ComActive, WriteData};
    endfunction

    task automatic tick(input bit v, input logic [7:0] d, input bit r);
        bit acc;
        reset    = r;
        rx_valid = v;
        rx_data  = d;
        acc = v && !r && (m_block == 0);
        @(posedge CLK);
        cyc++;
        if (r) begin
            m_block = 0; m_n = 0; m_idle = 0; m_wc = 0;
            m_word = 0; m_wdata = 0; m_strobe = 0; m_active = 0;
        end else begin
            if (m_strobe && m_wc < 65535) m_wc++;
            m_strobe = 0;
            if (m_block > 0) m_block--;
            if (acc) begin
                m_word = (m_word << 8) | {24'd0, d};
                m_n++;
                m_idle = 0;
                m_active = 1;
                if (m_n == 4) begin
                    m_wdata = m_word; m_word = 0; m_n = 0;
                    m_strobe = 1; m_block = 1 + GAP;
                end
            end else if (m_active) begin
                m_idle++;
                if (m_idle == T) begin
                    m_active = 0; m_n = 0; m_word = 0; m_idle = 0; m_wc = 0;
                end
            end
        end
        last_acc = acc;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 1);
        total++;
        if (obs_vec() !== 35'd0) begin
            bad++; $display("FAIL reset_values got=%h exp=%h", obs_vec(), 35'd0);
        end
        tick(0, 8'h00, 0);
        total++;
        if (rx_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_reset got=%b exp=1", rx_ready);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_word();
        logic [7:0] b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        tick(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1, b[i], 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        total++;
        if (WriteStrobe !== 1'b1 || WriteData !== 32'h12345678 || ComActive !== 1'b1) begin
            bad++; $display("FAIL single_word got=%b/%h/%b exp=1/12345678/1",
                            WriteStrobe, WriteData, ComActive);
        end
        tick(0, 8'h00, 0);
        total++;
        if (WriteStrobe !== 1'b0) begin
            bad++; $display("FAIL strobe_single_pulse got=%b exp=0", WriteStrobe);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] b[8];
        int strobes[$];
        int sent = 0;
        int low  = 0;
        logic [31:0] w1 = 32'd0;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        tick(0, 8'h00, 1);
        for (int i = 0; i < 25; i++) begin
            tick(sent < 8, b[(sent < 8) ? sent : 0], 0);
            if (last_acc) sent++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL bp_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (WriteStrobe === 1'b1) begin
                strobes.push_back(cyc);
                if (strobes.size() == 1) w1 = WriteData;
            end
            if (sent == 4 && rx_ready === 1'b0) low++;
        end
        total++;
        if (low != 1 + GAP) begin
            bad++; $display("FAIL bp_ready_low got=%0d exp=%0d", low, 1 + GAP);
        end
        total++;
        if (strobes.size() != 2 || sent != 8) begin
            bad++; $display("FAIL bp_strobe_count got=%0d/%0d exp=2/8", strobes.size(), sent);
        end else begin
            total++;
            if (strobes[1] - strobes[0] != 5 + GAP) begin
                bad++; $display("FAIL bp_strobe_spacing got=%0d exp=%0d",
                                strobes[1] - strobes[0], 5 + GAP);
            end
        end
        total++;
        if (w1 !== {b[0], b[1], b[2], b[3]} || WriteData !== {b[4], b[5], b[6], b[7]}) begin
            bad++; $display("FAIL bp_words got=%h/%h exp=%h/%h", w1, WriteData,
                            {b[0], b[1], b[2], b[3]}, {b[4], b[5], b[6], b[7]});
        end
    endtask

    task automatic test_timeout();
        logic [7:0] wb[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int a2, fall = -1, n = 0, g = 0;
        tick(0, 8'h00, 1);
        tick(1, 8'hAA, 0);
        tick(1, 8'hBB, 0);
        a2 = cyc;
        for (int i = 0; i < 40 && fall < 0; i++) begin
            tick(0, 8'h00, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL to_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (ComActive === 1'b0) fall = cyc;
        end
        total++;
        if (fall - a2 != T) begin
            bad++; $display("FAIL timeout_fall got=%0d exp=%0d", fall - a2, T);
        end
        while (n < 4 && g < 20) begin
            tick(1, wb[n], 0);
            g++;
            if (last_acc) n++;
        end
        total++;
        if (WriteStrobe !== 1'b1 || WriteData !== 32'h01020304) begin
            bad++; $display("FAIL timeout_new_word got=%b/%h exp=1/01020304", WriteStrobe, WriteData);
        end
    endtask

    task automatic test_accept_on_expiry();
        tick(0, 8'h00, 1);
        tick(1, 8'hC1, 0);
        for (int i = 0; i < T - 1; i++) tick(0, 8'h00, 0);
        tick(1, 8'hC2, 0);
        total++;
        if (ComActive !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL expiry_accept got=%b/%h exp=1/%h", ComActive, obs_vec(), exp_vec());
        end
        tick(1, 8'hC3, 0);
        tick(1, 8'hC4, 0);
        total++;
        if (WriteStrobe !== 1'b1 || WriteData !== 32'hC1C2C3C4) begin
            bad++; $display("FAIL expiry_word got=%b/%h exp=1/c1c2c3c4", WriteStrobe, WriteData);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        tick(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) tick(1, 8'hE0 + 8'(i), 0);
        tick(1, 8'hEE, 1);
        total++;
        if (obs_vec() !== 35'd0) begin
            bad++; $display("FAIL midword_reset got=%h exp=%h", obs_vec(), 35'd0);
        end
`ifdef USB_PACKER_WORDCOUNT_EN
        total++;
        if (word_count !== 16'd0) begin
            bad++; $display("FAIL midword_wc got=%0d exp=0", word_count);
        end
`endif
        for (int i = 0; i < 4; i++) tick(1, b[i], 0);
        total++;
        if (WriteStrobe !== 1'b1 || WriteData !== {b[0], b[1], b[2], b[3]}) begin
            bad++; $display("FAIL midword_clean got=%b/%h exp=1/%h", WriteStrobe, WriteData,
                            {b[0], b[1], b[2], b[3]});
        end
    endtask

    task automatic test_random();
        int pct = 50;
        tick(0, 8'h00, 1);
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 20;
                    2: pct = 60;
                    default: pct = 100;
                endcase
            end
            tick($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 499) == 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
`ifdef USB_PACKER_WORDCOUNT_EN
            total++;
            if (word_count !== 16'(m_wc)) begin
                bad++; $display("FAIL random_wc cyc=%0d got=%0d exp=%0d", cyc, word_count, m_wc);
            end
`endif
        end
    endtask

`ifdef USB_PACKER_WORDCOUNT_EN
    task automatic test_wordcount();
        int n = 0, g = 0;
        tick(0, 8'h00, 1);
        while (n < 12 && g < 60) begin
            tick(1, 8'($urandom), 0);
            g++;
            if (last_acc) n++;
        end
        for (int i = 0; i < 4; i++) tick(0, 8'h00, 0);
        total++;
        if (word_count !== 16'd3) begin
            bad++; $display("FAIL wc_three got=%0d exp=3", word_count);
        end
        g = 0;
        while (ComActive === 1'b1 && g < 40) begin
            tick(0, 8'h00, 0);
            g++;
        end
        total++;
        if (ComActive !== 1'b0 || word_count !== 16'd0) begin
            bad++; $display("FAIL wc_clear got=%b/%0d exp=0/0", ComActive, word_count);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge CLK);
        test_reset();
        test_single_word();
        test_back_pressure();
        test_timeout();
        test_accept_on_expiry();
        test_reset_mid_word();
`ifdef USB_PACKER_WORDCOUNT_EN
        test_wordcount();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
